mc_controller: RTL and testbench

// - Multicycle MIPS control unit: Moore FSM plus ALU decoder. Sits directly upstream of regfile;

---
 rtl/mips_pkg.sv | 57 +++++
 rtl/mc_controller_aludec.sv | 39 +++
 rtl/mc_controller.sv | 195 +++++++++++++++++++
 tb/tb_mc_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared encodings for the multicycle MIPS core: FSM states,
//               opcodes, R-type funct codes, aluop and alucontrol codes.
//               Reused by the controller, the ALU decoder, the ALU and the
//               datapath so every block agrees on one set of values.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Controller state encodings (4 bits, FETCH=0 .. JEX=11; 12-15 unused)
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // aluop: controller -> ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alucontrol: ALU decoder -> ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// ============================================================================
// Module      : aludec
// Description : Combinational ALU decoder. Maps the controller's aluop and
//               the instruction funct field to the 3-bit ALU control code.
// Ports       : aluop_i      in  2  operation class from the controller FSM
//               funct_i      in  6  instr[5:0], used only for aluop=10
//               alucontrol_o out 3  ALU operation select
// Revision    : 1.0 - initial release
// ============================================================================
module aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB:   alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    F_ADD:   alucontrol_o = ALU_ADD;
                    F_SUB:   alucontrol_o = ALU_SUB;
                    F_AND:   alucontrol_o = ALU_AND;
                    F_OR:    alucontrol_o = ALU_OR;
                    F_SLT:   alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            // 00 and the unused 11 code both mean add
            default:     alucontrol_o = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle MIPS control unit. Moore FSM sequencing each
//               instruction through 3-5 states, plus the ALU decoder and the
//               PC-enable gate (pcwrite | branch & zero).
// Ports       : clk        in  1  system clock, rising edge
//               reset      in  1  synchronous, active-high
//               op         in  6  instr[31:26]
//               funct      in  6  instr[5:0]
//               zero       in  1  ALU zero flag
//               pcen       out 1  PC load enable
//               irwrite    out 1  instruction register load
//               memwrite   out 1  data memory write
//               regwrite   out 1  register file write (we3)
//               iord       out 1  memory address: 0 PC, 1 ALUOut
//               memtoreg   out 1  wd3 source: 0 ALUOut, 1 Data
//               regdst     out 1  a3 source: 0 rt, 1 rd
//               alusrca    out 1  ALU A: 0 PC, 1 A
//               alusrcb    out 2  ALU B: 00 B, 01 4, 10 SignImm, 11 SignImm<<2
//               pcsrc      out 2  PC source: 00 ALUResult, 01 ALUOut, 10 jump
//               alucontrol out 3  ALU operation
//               state_dbg  out 4  current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state_dbg
);

    state_t     state_q;
    state_t     state_d;
    state_t     dec_state;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic [1:0] aluop;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. op is re-examined in MEMADR so a changed op can
    // never steer a non-memory instruction into a memory access.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_RTYPEEX;
                    OP_BEQ:   state_d = S_BEQEX;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JEX;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX and unused codes
            default:   state_d = S_FETCH;
        endcase
    end

    // While reset is held the datapath sees FETCH control values, so the
    // output decode runs on FETCH rather than on the (possibly stale)
    // register contents; the write enables are gated off separately.
    assign dec_state = reset ? S_FETCH : state_q;

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = ALUOP_ADD;
        case (dec_state)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                // Unused codes: everything stays at its default of 0
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Enable gating: no architectural write may escape while in reset
    // ------------------------------------------------------------------
    assign pcen      = ~reset & (pcwrite | (branch & zero));
    assign irwrite   = ~reset & irwrite_raw;
    assign memwrite  = ~reset & memwrite_raw;
    assign regwrite  = ~reset & regwrite_raw;
    assign state_dbg = state_q;

    aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller. A per-instruction
//               reference model expands each opcode into its expected
//               sequence of control cycles; directed and random
//               instructions are replayed against it cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    always #10 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state_dbg  (state_dbg)
    );

    // One expected control cycle, described by the named control lines
    typedef struct {
        logic [3:0] st;
        logic       pcwrite, branch, irwrite, memwrite, regwrite;
        logic       iord, memtoreg, regdst, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluctl;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [14:0] obs_vec;
    assign obs_vec = {pcen, irwrite, memwrite, regwrite, iord, memtoreg,
                      regdst, alusrca, alusrcb, pcsrc, alucontrol};

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e.st = st;       e.pcwrite = 1'b0; e.branch = 1'b0;  e.irwrite = 1'b0;
        e.memwrite = 1'b0; e.regwrite = 1'b0; e.iord = 1'b0; e.memtoreg = 1'b0;
        e.regdst = 1'b0; e.alusrca = 1'b0; e.alusrcb = 2'b00; e.pcsrc = 2'b00;
        e.aluctl = 3'b010;
        return e;
    endfunction

    function automatic logic [14:0] pack(input exp_t e, input logic z);
        return {e.pcwrite | (e.branch & z), e.irwrite, e.memwrite, e.regwrite,
                e.iord, e.memtoreg, e.regdst, e.alusrca, e.alusrcb, e.pcsrc, e.aluctl};
    endfunction

    function automatic logic [2:0] rtype_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;   // add
            6'b100010: return 3'b110;   // sub
            6'b100100: return 3'b000;   // and
            6'b100101: return 3'b001;   // or
            6'b101010: return 3'b111;   // slt
            default:   return 3'b010;
        endcase
    endfunction

    // Expand one instruction into its expected cycle list
    task automatic build(input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        q.delete();
        e = blank(4'd0); e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcwrite = 1'b1; q.push_back(e);
        e = blank(4'd1); e.alusrcb = 2'b11; q.push_back(e);
        case (o)
            6'b100011: begin // LW
                e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
                e = blank(4'd3); e.iord = 1'b1; q.push_back(e);
                e = blank(4'd4); e.memtoreg = 1'b1; e.regwrite = 1'b1; q.push_back(e);
            end
            6'b101011: begin // SW
                e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
                e = blank(4'd5); e.iord = 1'b1; e.memwrite = 1'b1; q.push_back(e);
            end
            6'b000000: begin // RTYPE
                e = blank(4'd6); e.alusrca = 1'b1; e.aluctl = rtype_ref(f); q.push_back(e);
                e = blank(4'd7); e.regdst = 1'b1; e.regwrite = 1'b1; q.push_back(e);
            end
            6'b000100: begin // BEQ
                e = blank(4'd8); e.alusrca = 1'b1; e.aluctl = 3'b110;
                e.pcsrc = 2'b01; e.branch = 1'b1; q.push_back(e);
            end
            6'b001000: begin // ADDI
                e = blank(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
                e = blank(4'd10); e.regwrite = 1'b1; q.push_back(e);
            end
            6'b000010: begin // J
                e = blank(4'd11); e.pcsrc = 2'b10; e.pcwrite = 1'b1; q.push_back(e);
            end
            default: ;       // illegal opcode: straight back to FETCH
        endcase
    endtask

    task automatic check(input string tag, input exp_t e);
        logic [14:0] ev;
        ev = pack(e, zero);
        n_cmp++;
        assert (state_dbg === e.st) else begin
            n_fail++;
            $error("FAIL %s.state: observed=%0d expected=%0d", tag, state_dbg, e.st);
        end
        n_cmp++;
        assert (obs_vec === ev) else begin
            n_fail++;
            $error("FAIL %s.outputs (st %0d): observed=%b expected=%b", tag, e.st, obs_vec, ev);
        end
    endtask

    // zmode < 0: random zero each cycle, otherwise zero held at zmode.
    // Each step checks 2 time units after the falling edge, then advances.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int limit);
        op    = o;
        funct = f;
        build(o, f);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #2;
            check(tag, q[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        fe;
        exp_t        me;
        logic [5:0]  ops[7];
        logic [5:0]  fns[6];
        logic [5:0]  o, f;

        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        // FETCH values with every enable held off
        fe = blank(4'd0);
        fe.alusrcb = 2'b01;

        // Reset
        reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
        @(negedge clk); @(negedge clk);
        #2;
        check("reset", fe);
        reset = 1'b0;

        // Directed instructions
        run_instr("lw",    6'b100011, 6'b000000, -1, 99);
        run_instr("add",   6'b000000, 6'b100000, -1, 99);
        run_instr("sub",   6'b000000, 6'b100010, -1, 99);
        run_instr("and",   6'b000000, 6'b100100, -1, 99);
        run_instr("or",    6'b000000, 6'b100101, -1, 99);
        run_instr("slt",   6'b000000, 6'b101010, -1, 99);
        run_instr("beq_t", 6'b000100, 6'b000000,  1, 99);
        run_instr("beq_n", 6'b000100, 6'b000000,  0, 99);
        run_instr("j",     6'b000010, 6'b000000, -1, 99);
        run_instr("sw",    6'b101011, 6'b000000, -1, 99);
        run_instr("addi",  6'b001000, 6'b000000, -1, 99);
        run_instr("ill",   6'b111111, 6'b000000,  1, 99);

        // Reset in MEMADR of SW: enables drop at once, FETCH next, no write
        run_instr("sw_abort", 6'b101011, 6'b000000, -1, 2);
        me = blank(4'd2); me.alusrca = 1'b1; me.alusrcb = 2'b10;
        #2;
        check("sw_abort.memadr", me);
        reset = 1'b1;
        #1;
        fe.st = 4'd2;
        check("sw_abort.rst_comb", fe);
        @(negedge clk);
        #2;
        fe.st = 4'd0;
        check("sw_abort.rst_fetch", fe);
        reset = 1'b0;
        run_instr("after_abort", 6'b001000, 6'b000000, -1, 99);

        // op changes away from LW while in MEMADR: back to FETCH
        run_instr("lw_chg", 6'b100011, 6'b000000, -1, 2);
        op = 6'b001000;
        #2;
        check("lw_chg.memadr", me);
        @(negedge clk);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 6) == 0) o = 6'($urandom);
            f = fns[$urandom_range(0, 5)];
            if (f == 6'b000000) f = 6'($urandom);
            run_instr("rand", o, f, -1, 99);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
